// File: rtl/systolic_ctrl.sv
// Sequencing controller for an NxN systolic MAC array: captures an operand pair,
// runs a fixed LOAD/FEED/DRAIN schedule and holds the captured result under valid/ready.
module systolic_ctrl #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int PE_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*N*DATA_W-1:0] matrix_A,
  input  logic [N*N*DATA_W-1:0] matrix_B,
  input  logic                  abort,
  output logic [N*N*DATA_W-1:0] a_reg,
  output logic [N*N*DATA_W-1:0] b_reg,
  output logic                  feed_load,
  output logic [N-1:0]          en_fr,
  output logic [N-1:0]          en_fc,
  output logic                  pe_clear,
  output logic                  pe_en,
  input  logic [N*N*ACC_W-1:0]  array_y,
  output logic [N*N*ACC_W-1:0]  y_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  busy
);

  localparam int FEED_LEN  = 2 * N - 1;
  localparam int DRAIN_LEN = 2 * (N - 1) + PE_LAT;
  localparam int MAX_LEN   = (FEED_LEN > DRAIN_LEN) ? FEED_LEN : DRAIN_LEN;
  localparam int CNT_W     = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N*N*DATA_W-1:0]   a_q, a_d;
  logic [N*N*DATA_W-1:0]   b_q, b_d;
  logic [N*N*ACC_W-1:0]    y_q, y_d;
  logic                    done_q, done_d;

  assign in_ready = (state_q == S_IDLE) && !abort;

  // Next-state logic. abort outranks every other request outside IDLE, so a
  // capture or handshake in the same cycle never takes effect.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    y_d     = y_q;
    done_d  = 1'b0;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            a_d     = matrix_A;
            b_d     = matrix_B;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
        S_FEED: begin
          if (cnt_q == FEED_LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            y_d     = array_y;
            done_d  = 1'b1;
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore decode; skew is pre-encoded as zero padding so all lanes shift together.
  always_comb begin
    feed_load = 1'b0;
    pe_clear  = 1'b0;
    pe_en     = 1'b0;
    en_fr     = '0;
    en_fc     = '0;
    out_valid = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        feed_load = 1'b1;
        pe_clear  = 1'b1;
      end
      S_FEED: begin
        en_fr = '1;
        en_fc = '1;
        pe_en = 1'b1;
      end
      S_DRAIN: pe_en     = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // the same pre-edge values; the wide operand/result registers are reset too
  // because their cleared value is visible on the ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign a_reg = a_q;
  assign b_reg = b_q;
  assign y_out = y_q;
  assign done  = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: a behavioural 4x4 array drives array_y,
// expected results come from a plain matrix product and the documented cycle schedule.
module tb_systolic_ctrl;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int OPW = N * N * DW;
  localparam int RW  = N * N * AW;
  localparam int LF  = 2 * N - 1;

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, abort;
  logic [OPW-1:0] matrix_A, matrix_B, a_reg, b_reg;
  logic           feed_load, pe_clear, pe_en;
  logic [N-1:0]   en_fr, en_fc;
  logic [RW-1:0]  array_y, y_out;
  logic           out_valid, out_ready, done, busy;

  systolic_ctrl #(.N(N), .DATA_W(DW), .ACC_W(AW), .PE_LAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .matrix_A(matrix_A), .matrix_B(matrix_B), .abort(abort),
    .a_reg(a_reg), .b_reg(b_reg), .feed_load(feed_load), .en_fr(en_fr), .en_fc(en_fc),
    .pe_clear(pe_clear), .pe_en(pe_en), .array_y(array_y), .y_out(y_out),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] last_y;

  typedef struct packed {
    logic       feed_load;
    logic [3:0] en_fr;
    logic [3:0] en_fc;
    logic       pe_clear;
    logic       pe_en;
    logic       busy;
    logic       out_valid;
    logic       done;
    logic       in_ready;
  } ctl_t;

  typedef struct {
    string          name;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [RW-1:0]  y;
    int             hold;
    bit             early;
  } vec_t;

  function automatic logic [DW-1:0] el(input logic [OPW-1:0] m, input int r, input int c);
    return m[(N*N-1-(r*N+c))*DW +: DW];
  endfunction

  function automatic logic [RW-1:0] matmul(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    logic [RW-1:0] y;
    logic [31:0]   s;
    y = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + 32'(el(a, i, k)) * 32'(el(b, k, j));
        y[(N*N-1-(i*N+j))*AW +: AW] = s;
      end
    return y;
  endfunction

  // Behavioural array: zero-padded skewed feeders and an output-stationary PE grid.
  logic [DW-1:0] fa [N][LF];
  logic [DW-1:0] fb [N][LF];
  logic [DW-1:0] ap [N][N];
  logic [DW-1:0] bp [N][N];
  logic [AW-1:0] acc[N][N];

  function automatic logic [DW-1:0] skew(input logic [OPW-1:0] m, input int lane, input int t,
                                         input bit is_a);
    if (t < lane || t - lane >= N) return '0;
    return is_a ? el(m, lane, t - lane) : el(m, t - lane, lane);
  endfunction

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return fa[i][0];
    return ap[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(input int i, input int j);
    if (i == 0) return fb[j][0];
    return bp[i-1][j];
  endfunction

  always @(posedge clk) begin
    if (feed_load) begin
      for (int l = 0; l < N; l++)
        for (int t = 0; t < LF; t++) begin
          fa[l][t] <= skew(a_reg, l, t, 1'b1);
          fb[l][t] <= skew(b_reg, l, t, 1'b0);
        end
    end else begin
      for (int l = 0; l < N; l++) begin
        if (en_fr[l]) begin
          for (int t = 0; t < LF - 1; t++) fa[l][t] <= fa[l][t+1];
          fa[l][LF-1] <= '0;
        end
        if (en_fc[l]) begin
          for (int t = 0; t < LF - 1; t++) fb[l][t] <= fb[l][t+1];
          fb[l][LF-1] <= '0;
        end
      end
    end
    if (pe_clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0;
          ap[i][j]  <= '0;
          bp[i][j]  <= '0;
        end
    end else if (pe_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
          ap[i][j]  <= a_in(i, j);
          bp[i][j]  <= b_in(i, j);
        end
    end
  end

  always_comb begin
    array_y = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) array_y[(N*N-1-(i*N+j))*AW +: AW] = acc[i][j];
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t cur_ctl();
    ctl_t c;
    c = '{feed_load, en_fr, en_fc, pe_clear, pe_en, busy, out_valid, done, in_ready};
    return c;
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t e;
    e = '0;
    e.in_ready = 1'b1;
    return e;
  endfunction

  // Expected controls c cycles after the acceptance edge (c=0 is the load cycle).
  function automatic ctl_t exp_ctl(input int c);
    ctl_t e;
    e = '0;
    e.busy = 1'b1;
    if (c == 0) begin
      e.feed_load = 1'b1;
      e.pe_clear  = 1'b1;
    end else if (c <= LF) begin
      e.en_fr = '1;
      e.en_fc = '1;
      e.pe_en = 1'b1;
    end else if (c <= 2 * LF) begin
      e.pe_en = 1'b1;
    end else begin
      e.out_valid = 1'b1;
      e.done      = (c == 2 * LF + 1);
    end
    return e;
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic poke_garbage();
    in_valid = 1'($urandom_range(0, 1));
    matrix_A = rnd_op();
    matrix_B = rnd_op();
  endtask

  // Entered and left at #1 after a rising edge with the controller idle.
  task automatic run_job(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                         input logic [RW-1:0] exp_y, input int hold, input bit early);
    matrix_A  = a;
    matrix_B  = b;
    in_valid  = 1'b1;
    out_ready = early;
    @(negedge clk);
    check($sformatf("%s idle", name), cur_ctl(), idle_ctl());
    @(posedge clk); #1;
    for (int c = 0; c <= 2 * LF + 1; c++) begin
      poke_garbage();
      @(negedge clk);
      check($sformatf("%s ctl c%0d", name, c), cur_ctl(), exp_ctl(c));
      check($sformatf("%s ops c%0d", name, c), {a_reg, b_reg}, {a, b});
      if (c == 2 * LF + 1) check($sformatf("%s y_out", name), y_out, exp_y);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        poke_garbage();
        @(negedge clk);
        check($sformatf("%s hold ctl h%0d", name, h), cur_ctl(), exp_ctl(2 * LF + 2 + h));
        check($sformatf("%s hold y h%0d", name, h), y_out, exp_y);
        @(posedge clk); #1;
      end
      poke_garbage();
      out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("%s release ctl", name), cur_ctl(), exp_ctl(2 * LF + 2 + hold));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check($sformatf("%s back idle", name), cur_ctl(), idle_ctl());
    check($sformatf("%s y kept", name), y_out, exp_y);
    check($sformatf("%s ops kept", name), {a_reg, b_reg}, {a, b});
    last_y = exp_y;
    @(posedge clk); #1;
  endtask

  task automatic abort_job(input string name, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                           input int at_c);
    logic [RW-1:0] exp_y;
    logic          seen;
    matrix_A = a;
    matrix_B = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (at_c) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    check($sformatf("%s ctl at abort", name), cur_ctl(), exp_ctl(at_c));
    @(posedge clk); #1;
    abort = 1'b0;
    exp_y = (at_c > 2 * LF) ? matmul(a, b) : last_y;
    @(negedge clk);
    check($sformatf("%s idle after abort", name), cur_ctl(), idle_ctl());
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | done | out_valid | busy;
    end
    check($sformatf("%s quiet after abort", name), RW'(seen), '0);
    check($sformatf("%s y after abort", name), y_out, exp_y);
    check($sformatf("%s ops after abort", name), {a_reg, b_reg}, {a, b});
    last_y = exp_y;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t           tbl[5];
    logic [OPW-1:0] p, q, ga;
    logic [RW-1:0]  id_y;

    reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    matrix_A = '0; matrix_B = '0; last_y = '0;

    id_y = '0;
    for (int e = 0; e < N * N; e++) id_y[(N*N-1-e)*AW +: AW] = 32'(e + 1);
    p = rnd_op();
    q = rnd_op();
    ga = rnd_op();
    tbl[0] = '{"identity", 128'h01000000_00010000_00000100_00000001,
               128'h01020304_05060708_090a0b0c_0d0e0f10, id_y, 0, 1'b0};
    tbl[1] = '{"all_ff", {OPW{1'b1}}, {OPW{1'b1}}, {16{32'h0003F804}}, 2, 1'b0};
    tbl[2] = '{"zeros_early", '0, '0, '0, 0, 1'b1};
    tbl[3] = '{"backpressure", p, q, matmul(p, q), 20, 1'b0};
    tbl[4] = '{"after_release", q, p, matmul(q, p), 1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset ctl", cur_ctl(), idle_ctl());
    check("reset y_out", y_out, '0);
    check("reset ops", {a_reg, b_reg}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++)
      run_job(tbl[t].name, tbl[t].a, tbl[t].b, tbl[t].y, tbl[t].hold, tbl[t].early);

    abort = 1'b1;
    in_valid = 1'b1;
    matrix_A = ga;
    matrix_B = ga;
    @(negedge clk);
    check("idle abort in_ready", RW'(in_ready), '0);
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("idle abort not accepted", RW'(busy), '0);
    check("idle abort ops", {a_reg, b_reg}, {tbl[4].a, tbl[4].b});
    @(posedge clk); #1;

    p = rnd_op(); q = rnd_op();
    abort_job("abort_feed3", p, q, 4);
    p = rnd_op(); q = rnd_op();
    run_job("after_abort", p, q, matmul(p, q), 1, 1'b0);
    p = rnd_op(); q = rnd_op();
    abort_job("abort_drain_last", p, q, 2 * LF);
    p = rnd_op(); q = rnd_op();
    abort_job("abort_done", p, q, 2 * LF + 1);

    p = rnd_op(); q = rnd_op();
    matrix_A = p;
    matrix_B = q;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midreset ctl", cur_ctl(), idle_ctl());
    check("midreset y_out", y_out, '0);
    check("midreset ops", {a_reg, b_reg}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("after reset idle", cur_ctl(), idle_ctl());
    last_y = '0;
    @(posedge clk); #1;
    run_job("after_reset", q, p, matmul(q, p), 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      p = rnd_op();
      q = rnd_op();
      run_job($sformatf("rand%0d", r), p, q, matmul(p, q), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
